// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } kscan_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] ROW_NONE = 4'b1111;

  // Active-low row decode: {valid, idx}; valid only when exactly one row is low.
  function automatic logic [2:0] onehot_row_idx(input logic [3:0] row);
    logic [2:0] res;
    case (row)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row inputs from the synchronizer, column drive and key outputs.
interface kscan_if;
  import keypad_pkg::*;

  logic [3:0] i_kscan_row;
  logic [3:0] o_kscan_col;
  key_code_t  o_kscan_key;
  logic       o_kscan_valid;
  logic       o_kscan_pressed;

  modport slave (
    input  i_kscan_row,
    output o_kscan_col,
    output o_kscan_key,
    output o_kscan_valid,
    output o_kscan_pressed
  );

  modport master (
    output i_kscan_row,
    input  o_kscan_col,
    input  o_kscan_key,
    input  o_kscan_valid,
    input  o_kscan_pressed
  );
endinterface

// File: rtl/kscan_tick.sv
// Free-running modulo-SETTLE_CYCLES counter; o_tick marks the last clock of each column dwell.
module kscan_tick #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic i_sys_clock,
  input  logic i_sys_reset,
  output logic o_tick_o
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign o_tick_o = (cnt_q == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, debounce, key code with one-cycle valid strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_CYCLES  = 50_000_000
) (
  input  logic   i_sys_clock,
  input  logic   i_sys_reset,
  kscan_if.slave kscan
);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  // The synchronizer adds latency, so shorter dwells would sample a stale column.
  if (SETTLE_CYCLES < 3 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("keypad_scanner: SETTLE_CYCLES must be >= 3 and REPEAT_CYCLES >= 1");
  end

  kscan_state_t   state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [1:0]     cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_code_t      key_q, key_d;
  logic           valid_q, valid_d;
  logic           pressed_q, pressed_d;
  logic           tick;
  logic [2:0]     row_dec;
  logic           row_ok;
  logic [1:0]     row_idx;

  kscan_tick #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_tick (
    .i_sys_clock (i_sys_clock),
    .i_sys_reset (i_sys_reset),
    .o_tick_o    (tick)
  );

  assign row_dec = onehot_row_idx(kscan.i_kscan_row);
  assign row_ok  = row_dec[2];
  assign row_idx = row_dec[1:0];

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d     = rpt_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (row_ok) begin
            cand_d  = row_idx;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (row_ok && (row_idx == cand_q)) begin
            if ((cnt_q + 1'b1) == CNT_LAST) begin
              key_d     = {cand_q, col_q};
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              cnt_d     = '0;
              state_d   = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_d     = '0;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer runs independently of the release debounce below.
        if (rpt_q == RPT_LAST) begin
          valid_d = 1'b1;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
        if (tick) begin
          if (kscan.i_kscan_row == ROW_NONE) begin
            if ((cnt_q + 1'b1) == CNT_LAST) begin
              pressed_d = 1'b0;
              cnt_d     = '0;
              col_d     = col_q + 2'd1;
              state_d   = ST_SCAN;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_d     = '0;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      state_q   <= ST_SCAN;
      col_q     <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign kscan.o_kscan_col     = ~(4'b0001 << col_q);
  assign kscan.o_kscan_key     = key_q;
  assign kscan.o_kscan_valid   = valid_q;
  assign kscan.o_kscan_pressed = pressed_q;
endmodule
